// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the eight-line interrupt front end:
//   IRQ_W       - number of request lines
//   ID_W        - width of an encoded request index
//   irq_state_t - presentation state (idle / presenting an index)
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int IRQ_W = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IRQ_IDLE    = 1'b0,
        IRQ_PRESENT = 1'b1
    } irq_state_t;

endpackage : irq_pkg

// File: rtl/priority_enc8_3.sv
// ---------------------------------------------------------------------------
// priority_enc8_3
// Eight-to-three priority encoder. Bit 7 has the highest priority.
// Ports:
//   d - request vector
//   y - index of the highest set bit in d (0 when d is all zero; callers
//       qualify y with their own "any bit set" flag)
// ---------------------------------------------------------------------------
module priority_enc8_3
    import irq_pkg::*;
(
    input  logic [IRQ_W-1:0] d,
    output logic [ID_W-1:0]  y
);

    // Scanning upward lets later (higher) bits overwrite lower ones, so the
    // last hit is the highest-priority request.
    always_comb begin
        y = '0;
        for (int i = 0; i < IRQ_W; i++) begin
            if (d[i]) begin
                y = ID_W'(i);
            end
        end
    end

endmodule : priority_enc8_3

// File: rtl/irq_ctrl8.sv
// ---------------------------------------------------------------------------
// irq_ctrl8
// Eight-line interrupt front end. Request lines are synchronised, turned into
// pending bits (edge or level mode), filtered by an enable mask, and the
// highest-priority eligible index is presented over a valid/ack handshake.
// Parameters:
//   EDGE_MODE - 1: a rising edge sets pending; 0: a high level sets pending
//   MASK_RST  - reset value of the enable mask (1 = enabled)
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   irq_in    - raw request lines, asynchronous to clk
//   mask_wr   - load mask_in into the mask register
//   mask_in   - new mask value
//   irq_ack   - consumer acknowledge, honoured only while irq_valid is high
//   irq_valid - an index is being presented
//   irq_id    - presented index, frozen while irq_valid is high
//   pending   - pending register readback
//   mask      - mask register readback
// ---------------------------------------------------------------------------
module irq_ctrl8
    import irq_pkg::*;
#(
    parameter int               EDGE_MODE = 1,
    parameter logic [IRQ_W-1:0] MASK_RST  = 8'hFF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_in,
    input  logic             mask_wr,
    input  logic [IRQ_W-1:0] mask_in,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [IRQ_W-1:0] pending,
    output logic [IRQ_W-1:0] mask
);

    logic [IRQ_W-1:0] s1;
    logic [IRQ_W-1:0] s2;
    logic [IRQ_W-1:0] set;
    logic [IRQ_W-1:0] clr;
    logic [IRQ_W-1:0] eligible;
    logic             any;
    logic [ID_W-1:0]  enc_y;
    irq_state_t       state;
    irq_state_t       state_next;
    logic             id_load;
    logic             ack_take;

    // Two-flop synchroniser; s2 doubles as the previous sample for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
        end
    end

    assign set = (EDGE_MODE != 0) ? (s1 & ~s2) : s1;

    // Clearing uses the frozen presented index, not the live encoder output,
    // so a newly arrived higher-priority bit can never be cleared by mistake.
    assign clr = ack_take ? (IRQ_W'(1) << irq_id) : '0;

    // Set is OR'd in after the clear so a fresh event coinciding with the ack
    // of the same line survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= MASK_RST;
        end else if (mask_wr) begin
            mask <= mask_in;
        end
    end

    assign eligible = pending & mask;
    assign any      = |eligible;

    priority_enc8_3 u_enc (
        .d (eligible),
        .y (enc_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IRQ_IDLE;
            irq_id <= '0;
        end else begin
            state <= state_next;
            if (id_load) begin
                irq_id <= enc_y;
            end
        end
    end

    // Once presenting, only an ack leaves the state: neither new arrivals nor
    // mask writes disturb the presented index.
    always_comb begin
        state_next = state;
        id_load    = 1'b0;
        ack_take   = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (any) begin
                    state_next = IRQ_PRESENT;
                    id_load    = 1'b1;
                end
            end
            IRQ_PRESENT: begin
                if (irq_ack) begin
                    state_next = IRQ_IDLE;
                    ack_take   = 1'b1;
                end
            end
            default: begin
                state_next = IRQ_IDLE;
            end
        endcase
    end

    assign irq_valid = (state == IRQ_PRESENT);

endmodule : irq_ctrl8

// File: tb/tb_irq_ctrl8.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl8
// Self-checking bench for irq_ctrl8 in its default edge mode.
// ---------------------------------------------------------------------------
module tb_irq_ctrl8;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic [7:0] mask;

    int checks;
    int failures;

    // Reference model state, kept in terms of the observable rules:
    // the last two sampled line values, the pending/mask sets and whether
    // an index is currently on offer.
    logic [7:0] m_hist1;
    logic [7:0] m_hist2;
    logic [7:0] m_pending;
    logic [7:0] m_mask;
    logic       m_presenting;
    logic [2:0] m_id;

    typedef struct {
        logic [7:0] irq;
        logic       ack;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pending;
    } vec_t;

    vec_t vecs[13];

    irq_ctrl8 dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .mask      (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_hist1      = '0;
        m_hist2      = '0;
        m_pending    = '0;
        m_mask       = 8'hFF;
        m_presenting = 1'b0;
        m_id         = '0;
    endtask

    // One clock edge of the behavioural model, using the inputs as driven now.
    task automatic model_step();
        logic [7:0] newly;
        logic [7:0] served;
        logic [7:0] elig;
        newly  = m_hist1 & ~m_hist2;
        served = '0;
        elig   = m_pending & m_mask;
        if (m_presenting) begin
            if (irq_ack) begin
                served[m_id] = 1'b1;
                m_presenting = 1'b0;
            end
        end else if (elig != 8'h00) begin
            for (int b = 7; b >= 0; b--) begin
                if (elig[b]) begin
                    m_id = 3'(b);
                    break;
                end
            end
            m_presenting = 1'b1;
        end
        m_pending = (m_pending & ~served) | newly;
        if (mask_wr) m_mask = mask_in;
        m_hist2 = m_hist1;
        m_hist1 = irq_in;
    endtask

    // Drive one cycle of inputs, advance past the edge and settle.
    task automatic applyStimulus(input logic [7:0] irq, input logic ack, input logic mwr, input logic [7:0] min);
        irq_in  = irq;
        irq_ack = ack;
        mask_wr = mwr;
        mask_in = min;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq_in = '0; irq_ack = 1'b0; mask_wr = 1'b0; mask_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();

        // Directed table: single request, priority order, spurious ack.
        vecs[0]  = '{8'h10, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[1]  = '{8'h10, 1'b0, 1'b0, 3'd0, 8'h10};
        vecs[2]  = '{8'h10, 1'b0, 1'b1, 3'd4, 8'h10};
        vecs[3]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        vecs[4]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[5]  = '{8'h42, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[6]  = '{8'h42, 1'b0, 1'b0, 3'd0, 8'h42};
        vecs[7]  = '{8'h42, 1'b0, 1'b1, 3'd6, 8'h42};
        vecs[8]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h02};
        vecs[9]  = '{8'h00, 1'b0, 1'b1, 3'd1, 8'h02};
        vecs[10] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
        vecs[12] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};

        do_reset();
        checkOutput("rst_valid", {7'd0, irq_valid}, 8'h00);
        checkOutput("rst_pending", pending, 8'h00);
        checkOutput("rst_mask", mask, 8'hFF);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].irq, vecs[i].ack, 1'b0, 8'h00);
            checkOutput($sformatf("vec%0d_valid", i), {7'd0, irq_valid}, {7'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pending);
            if (vecs[i].exp_valid)
                checkOutput($sformatf("vec%0d_id", i), {5'd0, irq_id}, {5'd0, vecs[i].exp_id});
        end

        // Mask hides line 6 until it is re-enabled.
        applyStimulus(8'h00, 1'b0, 1'b1, 8'hBF);
        checkOutput("mask_wr", mask, 8'hBF);
        applyStimulus(8'h42, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h42, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h42, 1'b0, 1'b0, 8'h00);
        checkOutput("mask_valid", {7'd0, irq_valid}, 8'h01);
        checkOutput("mask_id", {5'd0, irq_id}, 8'h01);
        checkOutput("mask_pending", pending, 8'h42);
        applyStimulus(8'h00, 1'b1, 1'b1, 8'hFF);
        checkOutput("mask_ack_valid", {7'd0, irq_valid}, 8'h00);
        checkOutput("mask_ack_pending", pending, 8'h40);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("mask_re_id", {5'd0, irq_id}, 8'h06);
        checkOutput("mask_re_valid", {7'd0, irq_valid}, 8'h01);
        applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
        checkOutput("mask_done", pending, 8'h00);

        // A fresh edge on line 2 lands on the very edge that acks line 2.
        applyStimulus(8'h04, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h04, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h04, 1'b0, 1'b0, 8'h00);
        checkOutput("sc_id", {5'd0, irq_id}, 8'h02);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h04, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
        checkOutput("sc_pending", pending, 8'h04);
        checkOutput("sc_gap", {7'd0, irq_valid}, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("sc_represent", {4'd0, irq_valid, irq_id}, 8'h0A);
        applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
        checkOutput("sc_clear", pending, 8'h00);

        // Line 7 arrives while line 0 is on offer: no pre-emption.
        applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h01, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h81, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h81, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h81, 1'b0, 1'b0, 8'h00);
        checkOutput("np_pending", pending, 8'h81);
        checkOutput("np_hold", {4'd0, irq_valid, irq_id}, 8'h08);
        applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("np_next", {4'd0, irq_valid, irq_id}, 8'h0F);
        applyStimulus(8'h00, 1'b1, 1'b0, 8'h00);

        // Reset mid-cycle while presenting, with a non-default mask.
        applyStimulus(8'h00, 1'b0, 1'b1, 8'h0F);
        applyStimulus(8'h08, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h08, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("pre_rst_valid", {4'd0, irq_valid, irq_id}, 8'h0B);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", {7'd0, irq_valid}, 8'h00);
        checkOutput("arst_id", {5'd0, irq_id}, 8'h00);
        checkOutput("arst_pending", pending, 8'h00);
        checkOutput("arst_mask", mask, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0, 8'h00);
        checkOutput("post_rst", {3'd0, irq_valid, pending[3:0]}, 8'h00);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
            checkOutput("rnd_valid", {7'd0, irq_valid}, {7'd0, m_presenting});
            checkOutput("rnd_pending", pending, m_pending);
            checkOutput("rnd_mask", mask, m_mask);
            if (m_presenting)
                checkOutput("rnd_id", {5'd0, irq_id}, {5'd0, m_id});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_ctrl8
